clause_vote_scheduler: RTL and testbench
========================================

Name: clause_vote_scheduler

Overview:
- Time-multiplexed inference controller for one Tsetlin Machine class.
- Sequences NUM_CLAUSES clause evaluations through a single shared clause-evaluation datapath, fetching each clause's exclude state from an external TA-state memory.
- Accumulates polarity-weighted votes into a clamped class sum.
- Sits between the feature-input stage and the class-compare (argmax) stage.

Parameters:
- NUM_FEATURES, 784, boolean features per sample.
- NUM_CLAUSES, 100, clauses for this class; must be even and at least 2.
- THRESHOLD, 15, vote clamp magnitude T; must be at least 1.
- SUM_W, 8, signed width of class_sum; must satisfy 2^(SUM_W-1) > THRESHOLD.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin an evaluation; sampled only in IDLE
- predict_mode  in  1  1 = inference rule (empty clause outputs 0); 0 = training rule (empty clause outputs 1); latched at start
- features  in  NUM_FEATURES  sample features; latched at start
- ta_rd_en  out  1  TA-state memory read strobe
- ta_rd_addr  out  clog2(NUM_CLAUSES)  clause index being fetched
- ta_rd_data  in  2*NUM_FEATURES  exclude state, valid exactly 1 cycle after ta_rd_en
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle pulse; class_sum valid
- class_sum  out  SUM_W  signed clamped vote sum, held until the next start is accepted

Behaviour:
- Reset values: busy=0, done=0, ta_rd_en=0, ta_rd_addr=0, class_sum=0, state=IDLE.
- Literal order: literals = {features, ~features}.
  - ta_rd_data[2F-1:F] masks the positive literals; ta_rd_data[F-1:0] masks the negated literals.
  - A bit value of 1 means the literal is excluded.
- Clause output: AND over (exclude | literals).
  - "Empty" means all 2F exclude bits are 1.
  - When predict_mode=1 and the clause is empty, the output is forced to 0.
- Polarity: even clause index votes +1, odd index votes -1.
- FSM IDLE -> FETCH -> DRAIN -> DONE -> IDLE:
  - IDLE: start=1 latches features and predict_mode, clears the accumulator, and moves to FETCH.
  - FETCH: ta_rd_en=1 and ta_rd_addr=k for the k-th FETCH cycle, k=0..N-1. After addr N-1 is issued, move to DRAIN.
  - Every cycle in which the delayed read-valid is high, the clause output for the returned data is accumulated.
  - DRAIN: accumulates the last clause (one cycle), then moves to DONE.
  - DONE: class_sum = clamp(acc, -T, +T) is registered and done=1 for one cycle, then return to IDLE.
- Timing:
  - Throughput is one clause per cycle.
  - With start sampled in cycle 0, done is high in cycle N+2.
  - busy is high in cycles 1..N+2.
- Accumulator width: clog2(NUM_CLAUSES)+2 bits, signed, never overflows. Clamping happens only at the output.
- start while busy is ignored. Changes to features or predict_mode while busy have no effect.
- start asserted in the same cycle as done is ignored, because the FSM is not in IDLE. A new start is accepted no earlier than cycle N+3.
- rst mid-operation: next cycle is IDLE with all outputs at reset values. No done is issued and the pending read result is discarded.
- ta_rd_addr holds its last value while ta_rd_en=0.

Decomposition:
- Package tm_pkg holds:
  - the literal-ordering convention
  - function clog2
  - the FSM state enum
  - a polarity helper (index LSB → ±1)
- Sub-module clause_eval:
  - purely combinational
  - inputs: features, exclude state, predict_mode
  - output: the clause bit, with empty detection
  - the only datapath instance in the block

Test Plan:
Benches use F=4, N=4, T=2 unless stated.
1. Clauses 0 and 2 have exclude=8'b1110_1111 (include feature[0]); clauses 1 and 3 are all-ones; predict_mode=1; features=4'b0001 -> done in cycle 6, class_sum=+2, busy high in cycles 1..6.
2. Same memory and predict_mode=1, features=4'b0000 -> class_sum=0. Repeat with predict_mode=0 and features=4'b0001 -> class_sum=+1-1+1-1=0.
3. N=8, T=2; even clauses fire and odd clauses are empty; predict_mode=1 -> raw sum +4, class_sum=+2 (clamped). Mirror with odd clauses firing -> -2.
4. Pulse start again in cycles 3 and 6 of a run, and change features in cycle 2 -> only one done, in cycle 6, result unchanged. Start in cycle 7 is accepted and done follows in cycle 13.
5. Assert rst in cycle 3 of a run -> cycle 4 shows busy=0, ta_rd_en=0, class_sum=0, and no done appears. A fresh start then completes normally.
6. Check ta_rd_addr sequence 0,1,2,3 in cycles 1..4 with ta_rd_en high only in those cycles. Check that done is exactly one cycle wide.

Source files
------------

// File: rtl/tm_pkg.sv
// Shared definitions for the Tsetlin Machine class-vote path.
//  - literal ordering: literals = {features, ~features}, so the upper F
//    exclude bits mask positive literals and the lower F mask negated ones
//  - clog2 for sizing counters/accumulators
//  - scheduler FSM state encoding
//  - clause polarity helper (even index votes +1, odd votes -1)
package tm_pkg;

  // Positive literals occupy the MSB half of the literal vector.
  localparam bit POS_LITS_MSB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic logic signed [1:0] polarity(input logic idx_lsb);
    return idx_lsb ? -2'sd1 : 2'sd1;
  endfunction

endpackage

// File: rtl/clause_eval.sv
// Combinational single-clause evaluator (the block's only datapath copy).
// Ports:
//  features     : sample features
//  exclude      : 2F exclude bits for this clause, 1 = literal excluded
//  predict_mode : 1 forces an empty clause (all literals excluded) to 0
//  clause_out   : clause output bit
module clause_eval
  import tm_pkg::*;
#(
  parameter int NUM_FEATURES = 784
) (
  input  logic [NUM_FEATURES-1:0]   features,
  input  logic [2*NUM_FEATURES-1:0] exclude,
  input  logic                      predict_mode,
  output logic                      clause_out
);

  logic [2*NUM_FEATURES-1:0] lits;
  logic                      empty;

  generate
    if (POS_LITS_MSB) begin : g_pos_hi
      assign lits = {features, ~features};
    end else begin : g_pos_lo
      assign lits = {~features, features};
    end
  endgenerate

  assign empty      = &exclude;
  assign clause_out = (&(exclude | lits)) & ~(predict_mode & empty);

endmodule

// File: rtl/clause_vote_scheduler.sv
// Time-multiplexed vote accumulator for one Tsetlin Machine class.
// Walks NUM_CLAUSES clause indices through one clause_eval, fetching each
// clause's exclude state from external TA memory (1-cycle read latency),
// and accumulates polarity-weighted clause outputs. The sum is clamped to
// [-THRESHOLD, +THRESHOLD] only when it is published on class_sum.
// Ports:
//  clk, rst      : clock, synchronous active-high reset
//  start         : begin evaluation (honoured only in IDLE)
//  predict_mode  : empty-clause rule select, latched at start
//  features      : sample features, latched at start
//  ta_rd_en/addr : TA-state memory read strobe and clause index
//  ta_rd_data    : exclude state, valid one cycle after ta_rd_en
//  busy          : evaluation in progress (through the done cycle)
//  done          : one-cycle pulse, class_sum valid
//  class_sum     : clamped signed vote sum, held between runs
module clause_vote_scheduler
  import tm_pkg::*;
#(
  parameter int NUM_FEATURES = 784,
  parameter int NUM_CLAUSES  = 100,
  parameter int THRESHOLD    = 15,
  parameter int SUM_W        = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             predict_mode,
  input  logic [NUM_FEATURES-1:0]          features,
  output logic                             ta_rd_en,
  output logic [clog2(NUM_CLAUSES)-1:0]    ta_rd_addr,
  input  logic [2*NUM_FEATURES-1:0]        ta_rd_data,
  output logic                             busy,
  output logic                             done,
  output logic signed [SUM_W-1:0]          class_sum
);

  localparam int ADDR_W = clog2(NUM_CLAUSES);
  localparam int ACC_W  = ADDR_W + 2;

  state_t                   state, state_nxt;
  logic [NUM_FEATURES-1:0]  feat_q;
  logic                     pm_q;
  logic [ADDR_W-1:0]        addr_q;
  logic                     rd_vld;      // ta_rd_data holds a requested clause
  logic                     rd_idx_lsb;  // parity of the clause in ta_rd_data
  logic signed [ACC_W-1:0]  acc, acc_nxt, contrib;
  logic                     clause_bit;
  logic                     last_addr;
  logic signed [1:0]        pol;

  function automatic logic signed [SUM_W-1:0] clamp_sum(input logic signed [ACC_W-1:0] a);
    int v;
    v = int'(a);
    if (v > THRESHOLD)       v = THRESHOLD;
    else if (v < -THRESHOLD) v = -THRESHOLD;
    return SUM_W'(v);
  endfunction

  clause_eval #(.NUM_FEATURES(NUM_FEATURES)) u_eval (
    .features     (feat_q),
    .exclude      (ta_rd_data),
    .predict_mode (pm_q),
    .clause_out   (clause_bit)
  );

  assign last_addr  = (addr_q == ADDR_W'(NUM_CLAUSES - 1));
  assign ta_rd_en   = (state == S_FETCH);
  assign ta_rd_addr = addr_q;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  assign pol     = polarity(rd_idx_lsb);
  assign contrib = (rd_vld && clause_bit) ? {{(ACC_W-2){pol[1]}}, pol} : '0;
  assign acc_nxt = acc + contrib;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: if (last_addr) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      feat_q     <= '0;
      pm_q       <= 1'b0;
      addr_q     <= '0;
      rd_vld     <= 1'b0;
      rd_idx_lsb <= 1'b0;
      acc        <= '0;
      class_sum  <= '0;
    end else begin
      rd_vld     <= ta_rd_en;
      rd_idx_lsb <= addr_q[0];
      if (state == S_IDLE && start) begin
        feat_q <= features;
        pm_q   <= predict_mode;
        addr_q <= '0;
        acc    <= '0;
      end else begin
        acc <= acc_nxt;
        if (state == S_FETCH && !last_addr) addr_q <= addr_q + 1'b1;
      end
      // DRAIN absorbs the final clause; publish so it is valid with done.
      if (state == S_DRAIN) class_sum <= clamp_sum(acc_nxt);
    end
  end

endmodule

// File: tb/tb_clause_vote_scheduler.sv
// Directed bench: F=4, T=2, with an N=4 instance and an N=8 instance.
module tb_clause_vote_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=4 instance
  logic              start4, pm4, en4, busy4, done4;
  logic [3:0]        feat4;
  logic [1:0]        addr4;
  logic [7:0]        rd4;
  logic signed [7:0] cs4;
  logic [7:0]        mem4 [4];

  // N=8 instance
  logic              start8, pm8, en8, busy8, done8;
  logic [3:0]        feat8;
  logic [2:0]        addr8;
  logic [7:0]        rd8;
  logic signed [7:0] cs8;
  logic [7:0]        mem8 [8];

  clause_vote_scheduler #(.NUM_FEATURES(4), .NUM_CLAUSES(4), .THRESHOLD(2), .SUM_W(8)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .predict_mode(pm4), .features(feat4),
    .ta_rd_en(en4), .ta_rd_addr(addr4), .ta_rd_data(rd4),
    .busy(busy4), .done(done4), .class_sum(cs4)
  );

  clause_vote_scheduler #(.NUM_FEATURES(4), .NUM_CLAUSES(8), .THRESHOLD(2), .SUM_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .predict_mode(pm8), .features(feat8),
    .ta_rd_en(en8), .ta_rd_addr(addr8), .ta_rd_data(rd8),
    .busy(busy8), .done(done8), .class_sum(cs8)
  );

  // TA memories, one-cycle read latency
  always @(posedge clk) if (en4) rd4 <= mem4[addr4];
  always @(posedge clk) if (en8) rd8 <= mem8[addr8];

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launches a run on dut4 in the current cycle (cycle 0) and checks
  // cycles 1..7; returns in cycle 7 (IDLE again).
  task automatic run4(input logic [3:0] f, input logic pm, input int exp);
    feat4 = f; pm4 = pm; start4 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick;
      if (c == 1) start4 = 1'b0;
      chk("busy4", int'(busy4), int'(c <= 6));
      chk("done4", int'(done4), int'(c == 6));
      chk("rd_en4", int'(en4), int'(c <= 4));
      if (c <= 4) chk("rd_addr4", int'(addr4), c - 1);
      if (c == 6) chk("sum4", int'(cs4), exp);
    end
  endtask

  // Same for dut8: done in cycle 10, returns in cycle 11.
  task automatic run8(input logic [3:0] f, input logic pm, input int exp);
    feat8 = f; pm8 = pm; start8 = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick;
      if (c == 1) start8 = 1'b0;
      chk("busy8", int'(busy8), int'(c <= 10));
      chk("done8", int'(done8), int'(c == 10));
      chk("rd_en8", int'(en8), int'(c <= 8));
      if (c <= 8) chk("rd_addr8", int'(addr8), c - 1);
      if (c == 10) chk("sum8", int'(cs8), exp);
    end
  endtask

  initial begin
    mem4[0] = 8'b1110_1111; mem4[1] = 8'hFF;
    mem4[2] = 8'b1110_1111; mem4[3] = 8'hFF;
    for (int i = 0; i < 8; i++) mem8[i] = (i % 2 == 0) ? 8'b1110_1111 : 8'hFF;
    rst = 1'b1;
    start4 = 1'b0; pm4 = 1'b0; feat4 = '0;
    start8 = 1'b0; pm8 = 1'b0; feat8 = '0;
    tick; tick;
    chk("rst_busy", int'(busy4), 0);
    chk("rst_done", int'(done4), 0);
    chk("rst_en", int'(en4), 0);
    chk("rst_addr", int'(addr4), 0);
    chk("rst_sum", int'(cs4), 0);
    rst = 1'b0;
    tick;

    // Single firing clause pair, empty odd clauses forced to 0 -> +2
    run4(4'b0001, 1'b1, 2);

    // Reset in cycle 3 aborts the run
    feat4 = 4'b0001; pm4 = 1'b1; start4 = 1'b1;
    tick; start4 = 1'b0;               // cycle 1
    tick;                              // cycle 2
    tick; rst = 1'b1;                  // cycle 3
    tick; rst = 1'b0;                  // cycle 4
    chk("abort_busy", int'(busy4), 0);
    chk("abort_en", int'(en4), 0);
    chk("abort_sum", int'(cs4), 0);
    chk("abort_done", int'(done4), 0);
    for (int c = 5; c <= 9; c++) begin
      tick;
      chk("abort_nodone", int'(done4), 0);
    end
    run4(4'b0001, 1'b1, 2);

    // Feature 0 low -> nothing fires -> 0
    run4(4'b0000, 1'b1, 0);
    // Training rule: empty clauses output 1 -> +1-1+1-1 = 0
    run4(4'b0001, 1'b0, 0);
    // Put a nonzero result back before the next zero-result case
    run4(4'b0001, 1'b1, 2);

    // Starts while busy ignored, feature change mid-run ignored,
    // start in cycle 7 accepted with the new features (result 0).
    feat4 = 4'b0001; pm4 = 1'b1; start4 = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick;
      chk("ovl_done", int'(done4), int'(c == 6 || c == 13));
      if (c == 6)  chk("ovl_sum1", int'(cs4), 2);
      if (c == 7)  chk("ovl_idle", int'(busy4), 0);
      if (c == 8)  chk("ovl_busy", int'(busy4), 1);
      if (c == 13) chk("ovl_sum2", int'(cs4), 0);
      start4 = (c == 3 || c == 6 || c == 7);
      if (c == 2) feat4 = 4'b0000;
    end

    // N=8: even clauses fire -> raw +4 clamped to +2
    run8(4'b0001, 1'b1, 2);
    // Mirror: odd clauses fire -> raw -4 clamped to -2
    for (int i = 0; i < 8; i++) mem8[i] = (i % 2 == 1) ? 8'b1110_1111 : 8'hFF;
    run8(4'b0001, 1'b1, -2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
